// File: rtl/dmem_responder.sv
// Data-port responder: word RAM plus TX FIFO/STATUS/CYCLES MMIO. ReadData is combinational; stores, pushes and pops commit on the edge.
// The TX stream stalls on OutReady low, and a push while full is dropped with sticky Overflow. The cycle counter exists only with DMEM_CYCLE_COUNTER_EN.
module dmem_responder #(
    parameter int MEM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [31:0] OutData,
    output logic        OutValid,
    input  logic        OutReady,
    output logic        Overflow
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_STATUS = 32'hFFFF_0004;
    localparam logic [31:0] ADDR_CYCLES = 32'hFFFF_0008;

    logic [31:0]   mem_q  [MEM_WORDS];
    logic [31:0]   fifo_q [FIFO_DEPTH];
    logic [31:0]   fifo_d [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic [31:0]   addr_word;
    logic [AW-1:0] ram_idx;
    logic          is_ram, is_tx, is_status, is_cycles;
    logic          fifo_full, fifo_empty;
    logic          push, pop, push_ok;
    logic [3:0]    status_cnt;
    logic [31:0]   cycles_rd;
    logic          unused_addr_lo;

    // Byte offset within a word never affects decode.
    assign unused_addr_lo = ^Addr[1:0];
    assign addr_word      = {Addr[31:2], 2'b00};
    assign ram_idx        = Addr[AW+1:2];
    assign is_ram         = (Addr[31:28] == 4'd0);
    assign is_tx          = (addr_word == ADDR_TXDATA);
    assign is_status      = (addr_word == ADDR_STATUS);
    assign is_cycles      = (addr_word == ADDR_CYCLES);

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop        = OutValid && OutReady;
    assign push       = MemWrite && is_tx;
    // A pop frees the slot at full, so push and pop both land.
    assign push_ok    = push && (!fifo_full || pop);
    assign status_cnt = 4'(count_q);

    always_comb begin
        fifo_d     = fifo_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_ok) begin
            fifo_d[wr_ptr_q] = WriteData;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CW'(1);
        end
        if (push && !push_ok) begin
            overflow_d = 1'b1;
        end else if (MemWrite && is_status && WriteData[0]) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (MemWrite && is_ram) begin
            mem_q[ram_idx] <= WriteData;
        end
    end

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] cycles_q, cycles_d;

    always_comb begin
        cycles_d = cycles_q + 32'd1;
        if (MemWrite && is_cycles) begin
            cycles_d = WriteData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign cycles_rd = cycles_q;
`else
    assign cycles_rd = '0;
`endif

    always_comb begin
        ReadData = '0;
        if (is_ram) begin
            ReadData = mem_q[ram_idx];
        end else if (is_status) begin
            ReadData = {24'b0, status_cnt, 1'b0, overflow_q, fifo_full, fifo_empty};
        end else if (is_cycles) begin
            ReadData = cycles_rd;
        end
    end

    assign OutValid = !fifo_empty;
    assign OutData  = fifo_q[rd_ptr_q];
    assign Overflow = overflow_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus a randomized mix checked against a queue/array reference model.
module tb_dmem_responder;
    localparam int MEM_WORDS  = 64;
    localparam int FIFO_DEPTH = 4;
    localparam logic [31:0] A_TX  = 32'hFFFF_0000;
    localparam logic [31:0] A_ST  = 32'hFFFF_0004;
    localparam logic [31:0] A_CYC = 32'hFFFF_0008;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] read_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    logic [31:0] mq[$];
    logic [31:0] mram[int];
    bit          m_ovf;
    logic [31:0] m_cyc;

    dmem_responder #(.MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .MemWrite (mem_write),
        .Addr     (addr),
        .WriteData(wdata),
        .ReadData (read_data),
        .OutData  (out_data),
        .OutValid (out_valid),
        .OutReady (out_ready),
        .Overflow (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int ram_idx(input logic [31:0] a);
        return int'((a >> 2) % MEM_WORDS);
    endfunction

    function automatic bit is_word(input logic [31:0] a, input logic [31:0] w);
        return ({a[31:2], 2'b00} == w);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:28] == 4'd0) return mram.exists(ram_idx(a)) ? mram[ram_idx(a)] : 32'hx;
        if (is_word(a, A_ST))
            return {24'b0, 4'(mq.size()), 1'b0, m_ovf, mq.size() == FIFO_DEPTH, mq.size() == 0};
        if (is_word(a, A_CYC)) return m_cyc;
        return 32'h0;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_ovf = 1'b0;
        m_cyc = 32'h0;
    endtask

    // Advance one rising edge and apply the same edge to the model.
    task automatic step();
        bit full, pop, push;
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            full = (mq.size() == FIFO_DEPTH);
            pop  = (mq.size() != 0) && out_ready;
            push = mem_write && is_word(addr, A_TX);
            if (pop) void'(mq.pop_front());
            if (push && (!full || pop)) mq.push_back(wdata);
            else if (push) m_ovf = 1'b1;
            if (mem_write && is_word(addr, A_ST) && wdata[0]) m_ovf = 1'b0;
            if (mem_write && addr[31:28] == 4'd0) mram[ram_idx(addr)] = wdata;
`ifdef DMEM_CYCLE_COUNTER_EN
            if (mem_write && is_word(addr, A_CYC)) m_cyc = wdata;
            else m_cyc = m_cyc + 32'd1;
`endif
        end
    endtask

    task automatic push_word(input logic [31:0] d);
        @(negedge clk);
        mem_write = 1'b1; addr = A_TX; wdata = d;
        step();
    endtask

    task automatic test_reset();
        @(negedge clk);
        addr = A_ST;
        #1;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_outvalid got=%b exp=0", out_valid); end
        vectors++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_outdata got=%h exp=0", out_data); end
        vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        vectors++; if (read_data !== 32'h1) begin errors++; $display("FAIL reset_status got=%h exp=00000001", read_data); end
        addr = A_CYC;
        #1;
        vectors++; if (read_data !== 32'h0) begin errors++; $display("FAIL reset_cycles got=%h exp=0", read_data); end
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_ram();
        @(negedge clk);
        mem_write = 1'b1; addr = 32'h10; wdata = 32'hDEAD_BEEF;
        step();
        @(negedge clk);
        mem_write = 1'b0; addr = 32'h10;
        #1;
        vectors++; if (read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_load got=%h exp=deadbeef", read_data); end
        addr = 32'h10 + 4 * MEM_WORDS;
        #1;
        vectors++; if (read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_wrap got=%h exp=deadbeef", read_data); end
        step();
        @(negedge clk);
        mem_write = 1'b1; addr = 32'h10; wdata = 32'h1234_5678;
        #1;
        vectors++; if (read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_same_cycle_old got=%h exp=deadbeef", read_data); end
        step();
        @(negedge clk);
        mem_write = 1'b0;
        #1;
        vectors++; if (read_data !== 32'h1234_5678) begin errors++; $display("FAIL ram_new got=%h exp=12345678", read_data); end
        step();
    endtask

    task automatic test_fifo_order();
        logic [31:0] vals [3] = '{32'h11, 32'h22, 32'h33};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word(vals[i]);
        @(negedge clk);
        mem_write = 1'b0; addr = A_ST;
        #1;
        vectors++; if (read_data !== 32'h30) begin errors++; $display("FAIL fifo_status3 got=%h exp=00000030", read_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (out_valid !== 1'b1 || out_data !== vals[i]) begin
                errors++; $display("FAIL fifo_order[%0d] got=%b/%h exp=1/%h", i, out_valid, out_data, vals[i]);
            end
            step();
            @(negedge clk);
        end
        #1;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fifo_drained got=%b exp=0", out_valid); end
        out_ready = 1'b0;
        step();
    endtask

    task automatic test_empty_push();
        @(negedge clk);
        mem_write = 1'b1; addr = A_TX; wdata = 32'h55; out_ready = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_no_bypass got=%b exp=0", out_valid); end
        step();
        @(negedge clk);
        mem_write = 1'b0; addr = A_ST;
        #1;
        vectors++; if (out_valid !== 1'b1 || out_data !== 32'h55 || read_data !== 32'h10) begin
            errors++; $display("FAIL empty_push got=%b/%h/%h exp=1/00000055/00000010", out_valid, out_data, read_data);
        end
        step();
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_push_pop got=%b exp=0", out_valid); end
        step();
    endtask

    task automatic test_overflow();
        int budget;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(32'hA0 + i);
        @(negedge clk);
        mem_write = 1'b0; addr = A_ST;
        #1;
        vectors++; if (read_data !== 32'h46 || overflow !== 1'b1 || out_data !== 32'hA0) begin
            errors++; $display("FAIL ovf_full got=%h/%b/%h exp=00000046/1/000000a0", read_data, overflow, out_data);
        end
        mem_write = 1'b1; addr = A_TX; wdata = 32'hB0; out_ready = 1'b1;
        step();
        @(negedge clk);
        mem_write = 1'b0; out_ready = 1'b0; addr = A_ST;
        #1;
        vectors++; if (read_data !== 32'h46 || overflow !== 1'b1 || out_data !== 32'hA1) begin
            errors++; $display("FAIL ovf_push_pop got=%h/%b/%h exp=00000046/1/000000a1", read_data, overflow, out_data);
        end
        mem_write = 1'b1; wdata = 32'h1;
        step();
        @(negedge clk);
        mem_write = 1'b0;
        #1;
        vectors++; if (overflow !== 1'b0 || read_data !== 32'h42) begin
            errors++; $display("FAIL ovf_clear got=%b/%h exp=0/00000042", overflow, read_data);
        end
        out_ready = 1'b1;
        budget = 10;
        while (mq.size() != 0 && budget > 0) begin
            #1;
            vectors++; if (out_valid !== 1'b1 || out_data !== mq[0]) begin
                errors++; $display("FAIL ovf_drain got=%b/%h exp=1/%h", out_valid, out_data, mq[0]);
            end
            step();
            @(negedge clk);
            budget--;
        end
        #1;
        vectors++; if (out_valid !== 1'b0 || budget == 0) begin
            errors++; $display("FAIL ovf_drain_end got=%b budget=%0d exp=0", out_valid, budget);
        end
        out_ready = 1'b0;
        step();
    endtask

    task automatic test_cycles();
        logic [31:0] exp [3];
`ifdef DMEM_CYCLE_COUNTER_EN
        exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
`else
        exp = '{32'h0, 32'h0, 32'h0};
`endif
        @(negedge clk);
        mem_write = 1'b1; addr = A_CYC; wdata = 32'hFFFF_FFFE;
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_write = 1'b0;
            #1;
            vectors++; if (read_data !== exp[i] || read_data !== m_cyc) begin
                errors++; $display("FAIL cycles[%0d] got=%h exp=%h", i, read_data, exp[i]);
            end
            step();
        end
    endtask

    task automatic test_random();
        logic [31:0] exp;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            mem_write = ($urandom_range(0, 1) == 1);
            wdata     = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 5))
                0, 1:    addr = A_TX | 32'($urandom_range(0, 3));
                2:       addr = A_ST;
                3:       addr = A_CYC;
                4:       addr = $urandom & 32'h0FFF_FFFF;
                default: addr = 32'h8000_0000 | 32'($urandom_range(0, 255));
            endcase
            #1;
            exp = model_read(addr);
            if (!$isunknown(exp)) begin
                vectors++; if (read_data !== exp) begin
                    errors++; $display("FAIL rand_read n=%0d addr=%h got=%h exp=%h", n, addr, read_data, exp);
                end
            end
            vectors++; if (out_valid !== (mq.size() != 0) || overflow !== m_ovf) begin
                errors++; $display("FAIL rand_flags n=%0d got=%b/%b exp=%b/%b", n, out_valid, overflow, mq.size() != 0, m_ovf);
            end
            if (mq.size() != 0) begin
                vectors++; if (out_data !== mq[0]) begin
                    errors++; $display("FAIL rand_head n=%0d got=%h exp=%h", n, out_data, mq[0]);
                end
            end
            step();
        end
        @(negedge clk);
        mem_write = 1'b0; out_ready = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 10 && (mq.size() < FIFO_DEPTH || !m_ovf); i++) push_word(32'hC0 + i);
        @(negedge clk);
        mem_write = 1'b0; out_ready = 1'b1;
        step();
        @(negedge clk);
        out_ready = 1'b0; addr = A_CYC;
        #1;
        vectors++; if (out_valid !== 1'b1 || overflow !== 1'b1 || mq.size() != 3) begin
            errors++; $display("FAIL arst_pre got=%b/%b exp=1/1 model_count=%0d", out_valid, overflow, mq.size());
        end
        #1;
        rst_n = 1'b0;
        #1;
        model_clear();
        vectors++; if (out_valid !== 1'b0 || overflow !== 1'b0 || out_data !== 32'h0 || read_data !== 32'h0) begin
            errors++; $display("FAIL arst_async got=%b/%b/%h/%h exp=0/0/0/0", out_valid, overflow, out_data, read_data);
        end
        step();
        @(negedge clk);
        rst_n = 1'b1; addr = A_ST;
        #1;
        vectors++; if (read_data !== 32'h1) begin errors++; $display("FAIL arst_status got=%h exp=00000001", read_data); end
        step();
    endtask

    initial begin
        rst_n = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0; out_ready = 1'b0;
        model_clear();
        test_reset();
        test_ram();
        test_fifo_order();
        test_empty_push();
        test_overflow();
        test_cycles();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
